// File: rtl/seq_multiplier_if.sv
// Request/result handshake between the execute stage and the iterative multiplier.
interface seq_multiplier_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, result_ready,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, op, a, b, result_ready,
    output busy, result_valid, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add 32x32 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operates on magnitudes for 32 iterations, then negates the 64-bit product when the signs differ.
module sum #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);
  localparam int              COUNT_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);
  localparam logic [COUNT_W-1:0] CNT_INIT = COUNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic               sa_reg;
  logic               sb_reg;
  logic [XLEN-1:0]    acc_hi_reg;
  logic [XLEN-1:0]    acc_lo_reg;
  logic [XLEN-1:0]    mcand_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [XLEN-1:0]    result_reg;
  logic               busy_reg;
  logic               valid_reg;

  logic            sa_next;
  logic            sb_next;
  logic [XLEN-1:0] mag_a_next;
  logic [XLEN-1:0] mag_b_next;
  logic [XLEN-1:0] neg_a_s;
  logic [XLEN-1:0] neg_b_s;
  logic            neg_a_c;
  logic            neg_b_c;
  logic [XLEN-1:0] step_s;
  logic            step_c;
  logic [XLEN:0]   step_next;
  logic [XLEN-1:0] neg_lo_s;
  logic [XLEN-1:0] neg_hi_s;
  logic            neg_lo_c;
  logic            neg_hi_c;
  logic [XLEN-1:0] fix_lo_next;
  logic [XLEN-1:0] fix_hi_next;
  logic            unused_carries;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  sum #(.W(XLEN)) u_neg_a  (.a(~bus.a),      .b(ONE),       .s(neg_a_s),  .cout(neg_a_c));
  sum #(.W(XLEN)) u_neg_b  (.a(~bus.b),      .b(ONE),       .s(neg_b_s),  .cout(neg_b_c));
  sum #(.W(XLEN)) u_step   (.a(acc_hi_reg),  .b(mcand_reg), .s(step_s),   .cout(step_c));
  sum #(.W(XLEN)) u_neg_lo (.a(~acc_lo_reg), .b(ONE),       .s(neg_lo_s), .cout(neg_lo_c));
  sum #(.W(XLEN)) u_neg_hi (.a(~acc_hi_reg), .b({{(XLEN-1){1'b0}}, neg_lo_c}),
                            .s(neg_hi_s), .cout(neg_hi_c));

  assign unused_carries = neg_a_c ^ neg_b_c ^ neg_hi_c;

  assign sa_next    = bus.a[XLEN-1] & ((bus.op == 2'b01) | (bus.op == 2'b10));
  assign sb_next    = bus.b[XLEN-1] & (bus.op == 2'b01);
  assign mag_a_next = sa_next ? neg_a_s : bus.a;
  assign mag_b_next = sb_next ? neg_b_s : bus.b;

  // 33-bit partial sum {carry, sum} that is shifted right into the 65-bit accumulator.
  assign step_next   = acc_lo_reg[0] ? {step_c, step_s} : {1'b0, acc_hi_reg};
  assign fix_lo_next = (sa_reg ^ sb_reg) ? neg_lo_s : acc_lo_reg;
  assign fix_hi_next = (sa_reg ^ sb_reg) ? neg_hi_s : acc_hi_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= 2'b00;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      mcand_reg  <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg     <= bus.op;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            acc_hi_reg <= '0;
            acc_lo_reg <= mag_b_next;
            mcand_reg  <= mag_a_next;
            count_reg  <= CNT_INIT;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          acc_hi_reg <= step_next[XLEN:1];
          acc_lo_reg <= {step_next[0], acc_lo_reg[XLEN-1:1]};
          count_reg  <= count_reg - 1'b1;
          if (count_reg == '0) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= (op_reg == 2'b00) ? fix_lo_next : fix_hi_next;
          busy_reg   <= 1'b0;
          valid_reg  <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_reg;
  assign bus.result_valid = valid_reg;
  assign bus.result       = result_reg;
endmodule
